mc_core_seq: RTL and testbench
==============================

MC_CORE_SEQ -- requirements
Module: mc_core_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IW, 9, instruction width
- AW, 8, PC / instruction address width
- DW, 8, branch offset width
- START_ADDR, 0, PC value loaded on start
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, the single clock; all state changes on its rising edge
- RST_N, in, 1, asynchronous active-low reset
- start, in, 1, launch or relaunch the program
- halt, out, 1, program stopped
- imem_req, out, 1, instruction fetch request
- imem_addr, out, AW, fetch address (equals pc)
- imem_valid, in, 1, fetch data valid pulse
- imem_data, in, IW, fetched instruction
- ir, out, IW, latched instruction register
- dec_halt, in, 1, decoded ir is a halt
- dec_mem, in, 1, decoded ir accesses data memory
- dec_load, in, 1, decoded ir is a load (valid with dec_mem)
- dec_wr, in, 1, decoded ir writes the register file
- dec_branch, in, 1, decoded ir is a branch
- taken, in, 1, branch condition true (sampled in EXEC)
- rel_jmp, in, DW, signed branch offset
- dmem_req, out, 1, data-memory request
- dmem_we, out, 1, data-memory write qualifier
- dmem_ready, in, 1, data access complete pulse
- reg_write, out, 1, register-file write strobe
- wb_sel, out, 1, write-back source (1 = memory, 0 = ALU)
- pc, out, AW, current program counter

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-004 IDLE or HALT with start=1 SHALL load pc=START_ADDR and go to FETCH. start SHALL be ignored in all other states.
REQ-005 In FETCH, imem_req SHALL be held at 1 until imem_valid=1. On that cycle ir SHALL capture imem_data and the FSM SHALL go to DECODE. Fetch latency is therefore unbounded.
REQ-006 DECODE SHALL last one cycle. dec_halt=1 SHALL go to HALT with pc unchanged; otherwise the FSM SHALL go to EXEC.
REQ-007 EXEC SHALL last one cycle:
- if dec_mem=1, go to MEM;
- otherwise pulse reg_write=dec_wr with wb_sel=0, update pc, and go to FETCH.
REQ-008 In MEM, dmem_req SHALL be held at 1 and dmem_we=!dec_load, until dmem_ready=1. Then:
- a store SHALL update pc and go to FETCH;
- a load SHALL go to WB.
REQ-009 WB SHALL pulse reg_write=1 with wb_sel=1 for one cycle, update pc, and go to FETCH.
REQ-010 pc update SHALL be pc+sign_extend(rel_jmp) when dec_branch&&taken, else pc+1, truncated modulo 2^AW (wrap-around, no error).
REQ-011 Branch condition and offset SHALL be sampled in EXEC only.
REQ-012 halt SHALL be 1 exactly while in HALT.
REQ-013 imem_req, dmem_req and reg_write SHALL be asserted only in the states named above and driven registered-free from state.
REQ-014 imem_valid outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-015 Minimum instruction latency SHALL be:
- 3 cycles for an ALU instruction with 1-cycle fetch;
- 4 cycles for a store with 1-cycle fetch and 1-cycle memory;
- 5 cycles for a load with 1-cycle fetch and 1-cycle memory.

Reset
REQ-016 RST_N=0 SHALL immediately set state=IDLE, pc=START_ADDR, ir=0, and all outputs 0, regardless of any in-flight access. Any in-flight access SHALL be abandoned.
REQ-017 The first action after reset release SHALL be waiting for start.

Configuration
REQ-018 With PERF_CNT_EN defined, the block SHALL add:
- output cyc_cnt[31:0], counting cycles spent outside IDLE/HALT;
- output ret_cnt[31:0], incremented once per completed instruction (each pc update).
Both counters SHALL clear on reset and on start, and wrap at 2^32.
REQ-019 Without PERF_CNT_EN, those ports and counters SHALL be absent and the behaviour SHALL be otherwise identical.

Structure
REQ-020 The state enum and the state-count constant SHALL live in shared package core_pkg.
REQ-021 The pc register and its next-value arithmetic SHALL be sub-module pc_unit, with inputs load, advance, branch, taken, offset and output pc.
REQ-022 The FSM, ir and the handshake outputs SHALL stay in mc_core_seq.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then start pulse with START_ADDR=0 and an ALU instruction with dec_wr=1 and 1-cycle imem -> reg_write pulse in cycle 3 with wb_sel=0, then pc=1.
- Branch at pc=0x10 with rel_jmp=0xFC and taken=1 -> pc=0x0C. With taken=0 -> pc=0x11.
- pc=0xFF with a non-branch instruction -> pc wraps to 0x00.
- Load with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then one WB cycle with reg_write=1 and wb_sel=1.
- dec_halt in DECODE -> halt=1 and pc held; start then gives pc=START_ADDR and halt=0. start pulses while in EXEC -> no effect.
- RST_N asserted mid-MEM -> dmem_req drops asynchronously and state=IDLE. With PERF_CNT_EN, 3 ALU instructions then halt -> ret_cnt=3 and cyc_cnt=9.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle sequencer: FSM state encoding and state count.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam int unsigned N_STATES = 7;

endpackage

// File: rtl/pc_unit.sv
// Program counter register: loads START_ADDR on launch, otherwise advances by 1 or by
// the sign-extended branch offset, wrapping modulo 2^AW.
module pc_unit #(
  parameter int unsigned       AW         = 8,
  parameter int unsigned       DW         = 8,
  parameter logic [AW-1:0]     START_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  logic          branch,
  input  logic          taken,
  input  logic [DW-1:0] offset,
  output logic [AW-1:0] pc
);

  logic [AW+DW-1:0] w_offset_ext;
  logic [AW-1:0]    w_step;
  logic [AW-1:0]    r_pc;

  // Sign-extend past AW so the low AW bits are correct whether DW is narrower or wider.
  assign w_offset_ext = {{AW{offset[DW-1]}}, offset};
  assign w_step       = (branch && taken) ? w_offset_ext[AW-1:0] : AW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= START_ADDR;
    end else if (load) begin
      r_pc <= START_ADDR;
    end else if (advance) begin
      r_pc <= r_pc + w_step;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/mc_core_seq.sv
// Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB) with start/halt control.
// Optional macro PERF_CNT_EN adds cyc_cnt/ret_cnt performance counters.
module mc_core_seq
  import core_pkg::*;
#(
  parameter int unsigned   IW         = 9,
  parameter int unsigned   AW         = 8,
  parameter int unsigned   DW         = 8,
  parameter logic [AW-1:0] START_ADDR = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  output logic          halt,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] ir,
  input  logic          dec_halt,
  input  logic          dec_mem,
  input  logic          dec_load,
  input  logic          dec_wr,
  input  logic          dec_branch,
  input  logic          taken,
  input  logic [DW-1:0] rel_jmp,
  output logic          dmem_req,
  output logic          dmem_we,
  input  logic          dmem_ready,
  output logic          reg_write,
  output logic          wb_sel,
  output logic [AW-1:0] pc
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]   cyc_cnt,
  output logic [31:0]   ret_cnt
`endif
);

  state_e        r_state;
  state_e        w_next;
  logic [IW-1:0] r_ir;
  logic          r_br_take;
  logic [DW-1:0] r_offset;
  logic          w_load;
  logic          w_advance;
  logic          w_branch;
  logic [DW-1:0] w_offset;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_HALT: if (start)      w_next = S_FETCH;
      S_FETCH:        if (imem_valid) w_next = S_DECODE;
      S_DECODE:       w_next = dec_halt ? S_HALT : S_EXEC;
      S_EXEC:         w_next = dec_mem ? S_MEM : S_FETCH;
      S_MEM:          if (dmem_ready) w_next = dec_load ? S_WB : S_FETCH;
      S_WB:           w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  // Output logic: handshakes decoded straight from the state register
  always_comb begin
    halt      = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 1'b0;
    unique case (r_state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  reg_write = dec_wr && !dec_mem;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = !dec_load;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = 1'b1;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  // Instruction register plus the branch decision captured in EXEC, so memory
  // instructions update pc later from values that were valid in EXEC.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ir      <= '0;
      r_br_take <= 1'b0;
      r_offset  <= '0;
    end else begin
      if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
      if (r_state == S_EXEC) begin
        r_br_take <= dec_branch && taken;
        r_offset  <= rel_jmp;
      end
    end
  end

  assign w_load    = (r_state == S_IDLE || r_state == S_HALT) && start;
  assign w_advance = (r_state == S_EXEC && !dec_mem)
                  || (r_state == S_MEM && dmem_ready && !dec_load)
                  || (r_state == S_WB);
  assign w_branch  = (r_state == S_EXEC) ? (dec_branch && taken) : r_br_take;
  assign w_offset  = (r_state == S_EXEC) ? rel_jmp : r_offset;

  pc_unit #(
    .AW         (AW),
    .DW         (DW),
    .START_ADDR (START_ADDR)
  ) u_pc_unit (
    .clk     (CLK),
    .rst_n   (RST_N),
    .load    (w_load),
    .advance (w_advance),
    .branch  (w_branch),
    .taken   (1'b1),
    .offset  (w_offset),
    .pc      (pc)
  );

  assign imem_addr = pc;
  assign ir        = r_ir;

`ifdef PERF_CNT_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_ret_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else if (w_load) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_advance)                              r_ret_cnt <= r_ret_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_mc_core_seq.sv
// Self-checking bench for mc_core_seq: table of instructions driven through the
// fetch/decode/exec/mem/wb handshakes, expected pc values checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_mc_core_seq;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic       halt;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid;
  logic [8:0] imem_data;
  logic [8:0] ir;
  logic       dec_halt, dec_mem, dec_load, dec_wr, dec_branch;
  logic       taken;
  logic [7:0] rel_jmp;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       reg_write, wb_sel;
  logic [7:0] pc;
`ifdef PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mc_core_seq #(.IW(9), .AW(8), .DW(8), .START_ADDR(8'h00)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .ir         (ir),
    .dec_halt   (dec_halt),
    .dec_mem    (dec_mem),
    .dec_load   (dec_load),
    .dec_wr     (dec_wr),
    .dec_branch (dec_branch),
    .taken      (taken),
    .rel_jmp    (rel_jmp),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ready (dmem_ready),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .pc         (pc)
`ifdef PERF_CNT_EN
    ,
    .cyc_cnt    (cyc_cnt),
    .ret_cnt    (ret_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [8:0] ir;
    int         fwait;
    bit         mem, load, wr, br, tk;
    logic [7:0] rel;
    int         mwait;
    bit         st_exec;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t       tbl[10];
  vec_t       alu3[3];
  logic [7:0] exp_q[$];
  logic [7:0] m_pc;
  int         n_checks = 0;
  int         n_pass   = 0;

  function automatic vec_t mk(logic [8:0] i, int fw, bit m, bit l, bit w, bit b, bit t,
                              logic [7:0] r, int mw, bit se, logic [7:0] e);
    vec_t v;
    v.ir = i; v.fwait = fw; v.mem = m; v.load = l; v.wr = w; v.br = b; v.tk = t;
    v.rel = r; v.mwait = mw; v.st_exec = se; v.exp_pc = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("fetch_reached", imem_req, 1);
  endtask

  task automatic do_instr(input vec_t v);
    logic [7:0] exp;
    wait_fetch();
    check("imem_addr", imem_addr, m_pc);
    for (int k = 0; k < v.fwait; k++) begin
      check("fetch_hold", imem_req, 1);
      @(negedge CLK);
    end
    imem_data  = v.ir;
    imem_valid = 1'b1;
    dec_halt   = 1'b0;
    dec_mem    = v.mem;
    dec_load   = v.load;
    dec_wr     = v.wr;
    dec_branch = v.br;
    taken      = !v.tk;
    rel_jmp    = ~v.rel;
    @(negedge CLK);                       // DECODE
    imem_valid = 1'b0;
    imem_data  = 9'h000;
    check("ir_latch", ir, v.ir);
    check("decode_no_req", imem_req, 0);
    @(negedge CLK);                       // EXEC
    check("exec_reg_write", reg_write, v.wr && !v.mem);
    check("exec_wb_sel", wb_sel, 0);
    taken   = v.tk;
    rel_jmp = v.rel;
    if (v.st_exec) start = 1'b1;
    exp_q.push_back(v.exp_pc);
    @(negedge CLK);
    start = 1'b0;
    if (v.mem) begin
      taken   = !v.tk;
      rel_jmp = ~v.rel;
      for (int k = 0; k <= v.mwait; k++) begin
        check("mem_dmem_req", dmem_req, 1);
        check("mem_dmem_we", dmem_we, !v.load);
        check("mem_no_reg_write", reg_write, 0);
        if (k == v.mwait) dmem_ready = 1'b1;
        @(negedge CLK);
      end
      dmem_ready = 1'b0;
      if (v.load) begin
        check("wb_reg_write", reg_write, 1);
        check("wb_sel", wb_sel, 1);
        check("wb_no_dmem_req", dmem_req, 0);
        @(negedge CLK);
      end
    end
    exp = exp_q.pop_front();
    check("pc_update", pc, exp);
    m_pc = exp;
  endtask

  task automatic do_halt();
    wait_fetch();
    imem_data  = 9'h1FF;
    imem_valid = 1'b1;
    dec_halt   = 1'b1;
    dec_mem    = 1'b0;
    dec_wr     = 1'b0;
    dec_branch = 1'b0;
    @(negedge CLK);
    imem_valid = 1'b0;
    check("decode_not_halt", halt, 0);
    @(negedge CLK);
    dec_halt = 1'b0;
    check("halt_set", halt, 1);
    check("halt_pc_held", pc, m_pc);
    repeat (2) @(negedge CLK);
    check("halt_stays", halt, 1);
    check("halt_no_fetch", imem_req, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    m_pc  = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(9'h1A0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 8'h01);
    tbl[1] = mk(9'h1A1, 2, 0, 0, 0, 1, 1, 8'h0F, 0, 0, 8'h10);
    tbl[2] = mk(9'h1A2, 0, 0, 0, 1, 1, 1, 8'hFC, 0, 1, 8'h0C);
    tbl[3] = mk(9'h1A3, 1, 0, 0, 0, 1, 1, 8'h04, 0, 0, 8'h10);
    tbl[4] = mk(9'h1A4, 0, 0, 0, 1, 1, 0, 8'hFC, 0, 0, 8'h11);
    tbl[5] = mk(9'h1A5, 0, 0, 0, 0, 1, 1, 8'hEE, 0, 0, 8'hFF);
    tbl[6] = mk(9'h1A6, 0, 0, 0, 1, 0, 1, 8'h05, 0, 0, 8'h00);
    tbl[7] = mk(9'h1A7, 0, 1, 0, 0, 1, 1, 8'h03, 1, 0, 8'h03);
    tbl[8] = mk(9'h1A8, 1, 1, 1, 1, 0, 0, 8'h00, 3, 0, 8'h04);
    tbl[9] = mk(9'h1A9, 0, 1, 1, 1, 1, 1, 8'h7C, 0, 0, 8'h80);
    for (int i = 0; i < 3; i++)
      alu3[i] = mk(9'h0C0 + 9'(i), 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 8'(i + 1));

    RST_N = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_data = '0;
    dec_halt = 1'b0; dec_mem = 1'b0; dec_load = 1'b0; dec_wr = 1'b0; dec_branch = 1'b0;
    taken = 1'b0; rel_jmp = '0; dmem_ready = 1'b0; m_pc = 8'h00;
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir, 9'h000);
    check("rst_halt", halt, 0);
    check("rst_imem_req", imem_req, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    imem_valid = 1'b1;                    // ignored while IDLE
    repeat (2) @(negedge CLK);
    imem_valid = 1'b0;
    check("idle_waits_start", imem_req, 0);
    check("idle_ir_untouched", ir, 9'h000);

    pulse_start();
    for (int i = 0; i < 10; i++) do_instr(tbl[i]);
    do_halt();

    pulse_start();
    check("restart_halt_clear", halt, 0);
    check("restart_pc", pc, 8'h00);
    check("restart_fetch", imem_req, 1);

    // Reset while a store is waiting for dmem_ready
    imem_data = 9'h1B0; imem_valid = 1'b1;
    dec_mem = 1'b1; dec_load = 1'b0; dec_wr = 1'b0; dec_branch = 1'b0;
    @(negedge CLK);
    imem_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check("pre_rst_dmem_req", dmem_req, 1);
    check("pre_rst_dmem_we", dmem_we, 1);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_dmem_req", dmem_req, 0);
    check("async_rst_dmem_we", dmem_we, 0);
    check("async_rst_ir", ir, 9'h000);
    check("async_rst_pc", pc, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    dec_mem = 1'b0;
    dmem_ready = 1'b1;                    // ignored outside MEM
    repeat (3) @(negedge CLK);
    dmem_ready = 1'b0;
    check("post_rst_idle", imem_req, 0);
    check("post_rst_no_dmem", dmem_req, 0);

`ifdef PERF_CNT_EN
    check("perf_rst_cyc", cyc_cnt, 0);
    check("perf_rst_ret", ret_cnt, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) do_instr(alu3[i]);
    check("perf_ret_3", ret_cnt, 3);
    check("perf_cyc_9", cyc_cnt, 9);
    do_halt();
    check("perf_ret_halt", ret_cnt, 3);
    check("perf_cyc_halt", cyc_cnt, 11);
    pulse_start();
    check("perf_clear_cyc", cyc_cnt, 0);
    check("perf_clear_ret", ret_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
